// File: rtl/rom_dl_ctrl.sv
// Program-ROM download controller: captures HPS download bytes into a shared
// single-port RAM, holds the core in reset around loads, and serves CPU reads.
module rom_dl_ctrl #(
  parameter int          ROM_SIZE    = 16384,
  parameter int          HOLD_CYCLES = 256,
  parameter logic [7:0]  DL_INDEX    = 8'd0
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        ioctl_wait,
  input  logic        cpu_req,
  input  logic [13:0] cpu_addr,
  output logic        cpu_ack,
  output logic [7:0]  cpu_rdata,
  output logic [13:0] mem_addr,
  output logic [7:0]  mem_din,
  output logic        mem_we,
  input  logic [7:0]  mem_dout,
  output logic        core_reset,
  output logic        dl_done,
  output logic        dl_err,
  output logic [1:0]  fsm_state
);

  typedef enum logic [1:0] {ST_HOLD = 2'd0, ST_RUN = 2'd1, ST_LOAD = 2'd2, ST_DRAIN = 2'd3} state_t;

  localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  state_t        state, state_nxt;
  logic [CW-1:0] hold_cnt;
  logic          hold_last;
  logic          from_drain;
  logic          buf_full;
  logic [13:0]   buf_addr;
  logic [7:0]    buf_data;
  logic          ack_q;

  logic dl_sel, load_start, in_range, byte_take, byte_bad;

  // Handshake: a byte is offered when ioctl_wr is high for one cycle. It is
  // accepted only if the buffer is empty (ioctl_wait low) and the address is in
  // range; otherwise it is dropped and dl_err is set. Accepted bytes reach the
  // RAM on the following cycle.
  assign dl_sel     = ioctl_download && (ioctl_index == DL_INDEX);
  assign load_start = dl_sel && (state != ST_LOAD);
  assign in_range   = ioctl_addr < 25'(ROM_SIZE);
  assign byte_take  = dl_sel && ioctl_wr && !buf_full && in_range;
  assign byte_bad   = dl_sel && ioctl_wr && (buf_full || !in_range);
  assign hold_last  = (state == ST_HOLD) && (hold_cnt == CW'(HOLD_CYCLES - 1));

  always_comb begin
    state_nxt = state;
    if (load_start) begin
      state_nxt = ST_LOAD;
    end else begin
      case (state)
        ST_HOLD:  if (hold_last) state_nxt = ST_RUN;
        ST_LOAD:  if (!dl_sel) state_nxt = ST_DRAIN;
        ST_DRAIN: if (!buf_full) state_nxt = ST_HOLD;
        default:  state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state      <= ST_HOLD;
      hold_cnt   <= '0;
      from_drain <= 1'b0;
      buf_full   <= 1'b0;
      buf_addr   <= '0;
      buf_data   <= '0;
      dl_done    <= 1'b0;
      dl_err     <= 1'b0;
      ack_q      <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == ST_DRAIN && state_nxt == ST_HOLD) begin
        hold_cnt   <= '0;
        from_drain <= 1'b1;
      end else if (state == ST_HOLD && !hold_last) begin
        hold_cnt <= hold_cnt + CW'(1);
      end
      if (hold_last && from_drain) dl_done <= 1'b1;
      // An error in the start cycle must survive the start-of-load clear.
      if (byte_bad)        dl_err <= 1'b1;
      else if (load_start) dl_err <= 1'b0;
      buf_full <= byte_take;
      if (byte_take) begin
        buf_addr <= ioctl_addr[13:0];
        buf_data <= ioctl_dout;
      end
      ack_q <= (state == ST_RUN) && cpu_req && !load_start;
    end
  end

  // Gating mem_we with reset discards a byte pending when reset hits.
  assign mem_we     = buf_full && !reset;
  assign mem_addr   = buf_full ? buf_addr : cpu_addr;
  assign mem_din    = buf_data;
  assign ioctl_wait = buf_full;
  assign cpu_ack    = ack_q;
  assign cpu_rdata  = ack_q ? mem_dout : 8'h00;
  assign core_reset = (state != ST_RUN);
  assign fsm_state  = state;

endmodule

// File: tb/tb_rom_dl_ctrl.sv
// Directed bench for rom_dl_ctrl with a registered-read RAM model and a log of
// every RAM write for comparison against expected writes.
module tb_rom_dl_ctrl;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        ioctl_wait;
  logic        cpu_req;
  logic [13:0] cpu_addr;
  logic        cpu_ack;
  logic [7:0]  cpu_rdata;
  logic [13:0] mem_addr;
  logic [7:0]  mem_din;
  logic        mem_we;
  logic [7:0]  mem_dout;
  logic        core_reset;
  logic        dl_done;
  logic        dl_err;
  logic [1:0]  fsm_state;

  localparam logic [1:0] S_HOLD = 2'd0, S_RUN = 2'd1, S_LOAD = 2'd2, S_DRAIN = 2'd3;

  int n_pass = 0;
  int n_total = 0;

  logic [7:0]  mem [0:16383];
  logic [21:0] wr_log[$];
  logic [21:0] exp_q[$];

  rom_dl_ctrl #(.ROM_SIZE(16384), .HOLD_CYCLES(256), .DL_INDEX(8'd0)) dut (
    .clk_sys(clk_sys), .reset(reset),
    .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .ioctl_wait(ioctl_wait),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .mem_dout(mem_dout),
    .core_reset(core_reset), .dl_done(dl_done), .dl_err(dl_err), .fsm_state(fsm_state)
  );

  // clock / RAM model
  always #5 clk_sys = ~clk_sys;

  always @(posedge clk_sys) begin
    if (mem_we === 1'b1) begin
      mem[mem_addr] <= mem_din;
      wr_log.push_back({mem_addr, mem_din});
    end
    mem_dout <= mem[mem_addr];
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  // driver tasks
  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic wait_run(output int cycles, output bit timeout);
    cycles = 0;
    while (core_reset === 1'b1 && cycles < 2000) begin
      cycles++;
      step();
    end
    timeout = (cycles >= 2000);
  endtask

  task automatic finish_load();
    int n;
    bit to;
    ioctl_download = 1'b0;
    step();
    step();
    wait_run(n, to);
    n_total++;
    if (to) $display("FAIL finish_load_timeout got=%0d cycles exp=<2000", n); else n_pass++;
  endtask

  task automatic test_reset();
    int n;
    bit to;
    reset = 1'b1;
    step();
    step();
    n_total++; if (core_reset !== 1'b1) $display("FAIL rst_core_reset got=%b exp=1", core_reset); else n_pass++;
    n_total++; if (ioctl_wait !== 1'b0) $display("FAIL rst_ioctl_wait got=%b exp=0", ioctl_wait); else n_pass++;
    n_total++; if (mem_we !== 1'b0) $display("FAIL rst_mem_we got=%b exp=0", mem_we); else n_pass++;
    n_total++; if (cpu_ack !== 1'b0) $display("FAIL rst_cpu_ack got=%b exp=0", cpu_ack); else n_pass++;
    n_total++; if (cpu_rdata !== 8'h00) $display("FAIL rst_cpu_rdata got=%h exp=00", cpu_rdata); else n_pass++;
    n_total++; if (dl_done !== 1'b0) $display("FAIL rst_dl_done got=%b exp=0", dl_done); else n_pass++;
    n_total++; if (dl_err !== 1'b0) $display("FAIL rst_dl_err got=%b exp=0", dl_err); else n_pass++;
    n_total++; if (fsm_state !== S_HOLD) $display("FAIL rst_state got=%0d exp=%0d", fsm_state, S_HOLD); else n_pass++;
    reset = 1'b0;
    wait_run(n, to);
    n_total++; if (n !== 256) $display("FAIL rst_hold_len got=%0d exp=256", n); else n_pass++;
    n_total++; if (fsm_state !== S_RUN) $display("FAIL rst_to_run got=%0d exp=%0d", fsm_state, S_RUN); else n_pass++;
    n_total++; if (dl_done !== 1'b0) $display("FAIL rst_no_done got=%b exp=0", dl_done); else n_pass++;
  endtask

  task automatic test_load();
    logic [7:0] ld_data [4];
    int waits;
    int n;
    bit to;
    ld_data = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    waits = 0;
    wr_log.delete();
    exp_q.delete();
    ioctl_index = 8'd0;
    ioctl_download = 1'b1;
    step();
    n_total++; if (fsm_state !== S_LOAD) $display("FAIL load_enter got=%0d exp=%0d", fsm_state, S_LOAD); else n_pass++;
    n_total++; if (core_reset !== 1'b1) $display("FAIL load_core_reset got=%b exp=1", core_reset); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      ioctl_wr = 1'b1;
      ioctl_addr = 25'(i);
      ioctl_dout = ld_data[i];
      exp_q.push_back({14'(i), ld_data[i]});
      step();
      ioctl_wr = 1'b0;
      n_total++; if (mem_we !== 1'b1) $display("FAIL load_we[%0d] got=%b exp=1", i, mem_we); else n_pass++;
      n_total++; if (mem_addr !== 14'(i)) $display("FAIL load_addr[%0d] got=%h exp=%h", i, mem_addr, 14'(i)); else n_pass++;
      n_total++; if (mem_din !== ld_data[i]) $display("FAIL load_din[%0d] got=%h exp=%h", i, mem_din, ld_data[i]); else n_pass++;
      if (ioctl_wait === 1'b1) waits++;
      for (int k = 0; k < 3; k++) begin
        step();
        if (ioctl_wait === 1'b1) waits++;
      end
    end
    n_total++; if (waits !== 4) $display("FAIL load_wait_cycles got=%0d exp=4", waits); else n_pass++;
    ioctl_download = 1'b0;
    step();
    n_total++; if (fsm_state !== S_DRAIN) $display("FAIL load_drain got=%0d exp=%0d", fsm_state, S_DRAIN); else n_pass++;
    step();
    n_total++; if (fsm_state !== S_HOLD) $display("FAIL load_hold got=%0d exp=%0d", fsm_state, S_HOLD); else n_pass++;
    n_total++; if (dl_done !== 1'b0) $display("FAIL load_done_early got=%b exp=0", dl_done); else n_pass++;
    wait_run(n, to);
    n_total++; if (n !== 256) $display("FAIL load_hold_len got=%0d exp=256", n); else n_pass++;
    n_total++; if (dl_done !== 1'b1) $display("FAIL load_done got=%b exp=1", dl_done); else n_pass++;
    n_total++; if (dl_err !== 1'b0) $display("FAIL load_err got=%b exp=0", dl_err); else n_pass++;
    n_total++; if (wr_log.size() !== 4) $display("FAIL load_wr_count got=%0d exp=4", wr_log.size()); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      logic [21:0] got;
      got = (i < wr_log.size()) ? wr_log[i] : 22'bx;
      n_total++; if (got !== exp_q[i]) $display("FAIL load_wr_log[%0d] got=%h exp=%h", i, got, exp_q[i]); else n_pass++;
    end
  endtask

  task automatic test_cpu_read();
    cpu_req = 1'b1;
    cpu_addr = 14'h0002;
    #1;
    n_total++; if (mem_addr !== 14'h0002) $display("FAIL cpu_mem_addr got=%h exp=0002", mem_addr); else n_pass++;
    n_total++; if (mem_we !== 1'b0) $display("FAIL cpu_mem_we got=%b exp=0", mem_we); else n_pass++;
    step();
    cpu_addr = 14'h0003;
    n_total++; if (cpu_ack !== 1'b1) $display("FAIL cpu_ack0 got=%b exp=1", cpu_ack); else n_pass++;
    n_total++; if (cpu_rdata !== 8'hCC) $display("FAIL cpu_rdata0 got=%h exp=cc", cpu_rdata); else n_pass++;
    step();
    cpu_req = 1'b0;
    n_total++; if (cpu_ack !== 1'b1) $display("FAIL cpu_ack1 got=%b exp=1", cpu_ack); else n_pass++;
    n_total++; if (cpu_rdata !== 8'hDD) $display("FAIL cpu_rdata1 got=%h exp=dd", cpu_rdata); else n_pass++;
    step();
    n_total++; if (cpu_ack !== 1'b0) $display("FAIL cpu_ack_end got=%b exp=0", cpu_ack); else n_pass++;
  endtask

  task automatic test_oob();
    int n;
    bit to;
    ioctl_download = 1'b1;
    step();
    wr_log.delete();
    ioctl_wr = 1'b1;
    ioctl_addr = 25'h0004000;
    ioctl_dout = 8'hEE;
    step();
    ioctl_wr = 1'b0;
    n_total++; if (mem_we !== 1'b0) $display("FAIL oob_mem_we got=%b exp=0", mem_we); else n_pass++;
    n_total++; if (ioctl_wait !== 1'b0) $display("FAIL oob_wait got=%b exp=0", ioctl_wait); else n_pass++;
    n_total++; if (dl_err !== 1'b1) $display("FAIL oob_err got=%b exp=1", dl_err); else n_pass++;
    ioctl_download = 1'b0;
    step();
    step();
    wait_run(n, to);
    n_total++; if (n !== 256) $display("FAIL oob_hold_len got=%0d exp=256", n); else n_pass++;
    n_total++; if (fsm_state !== S_RUN) $display("FAIL oob_run got=%0d exp=%0d", fsm_state, S_RUN); else n_pass++;
    n_total++; if (dl_err !== 1'b1) $display("FAIL oob_err_sticky got=%b exp=1", dl_err); else n_pass++;
    n_total++; if (wr_log.size() !== 0) $display("FAIL oob_no_write got=%0d exp=0", wr_log.size()); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [21:0] got;
    ioctl_download = 1'b1;
    step();
    n_total++; if (dl_err !== 1'b0) $display("FAIL b2b_err_clear got=%b exp=0", dl_err); else n_pass++;
    wr_log.delete();
    ioctl_wr = 1'b1;
    ioctl_addr = 25'h20;
    ioctl_dout = 8'h11;
    step();
    ioctl_addr = 25'h21;
    ioctl_dout = 8'h22;
    step();
    ioctl_wr = 1'b0;
    n_total++; if (dl_err !== 1'b1) $display("FAIL b2b_err got=%b exp=1", dl_err); else n_pass++;
    n_total++; if (mem_we !== 1'b0) $display("FAIL b2b_mem_we got=%b exp=0", mem_we); else n_pass++;
    step();
    step();
    n_total++; if (wr_log.size() !== 1) $display("FAIL b2b_wr_count got=%0d exp=1", wr_log.size()); else n_pass++;
    got = (wr_log.size() > 0) ? wr_log[0] : 22'bx;
    n_total++; if (got !== {14'h0020, 8'h11}) $display("FAIL b2b_wr_log got=%h exp=%h", got, {14'h0020, 8'h11}); else n_pass++;
    finish_load();
  endtask

  task automatic test_other_index();
    int bad;
    bad = 0;
    wr_log.delete();
    ioctl_index = 8'd1;
    ioctl_download = 1'b1;
    for (int i = 0; i < 6; i++) begin
      ioctl_wr = (i % 2 == 0);
      ioctl_addr = 25'h0;
      ioctl_dout = 8'h99;
      step();
      if (fsm_state !== S_RUN || core_reset !== 1'b0 || ioctl_wait !== 1'b0 || mem_we !== 1'b0) bad++;
    end
    ioctl_wr = 1'b0;
    ioctl_download = 1'b0;
    ioctl_index = 8'd0;
    n_total++; if (bad !== 0) $display("FAIL idx_ignored got=%0d bad cycles exp=0", bad); else n_pass++;
    step();
    n_total++; if (wr_log.size() !== 0) $display("FAIL idx_no_write got=%0d exp=0", wr_log.size()); else n_pass++;
    cpu_req = 1'b1;
    cpu_addr = 14'h0000;
    step();
    cpu_req = 1'b0;
    n_total++; if (cpu_rdata !== 8'hAA) $display("FAIL idx_mem_intact got=%h exp=aa", cpu_rdata); else n_pass++;
  endtask

  task automatic test_reset_mid_load();
    ioctl_download = 1'b1;
    step();
    wr_log.delete();
    ioctl_wr = 1'b1;
    ioctl_addr = 25'h30;
    ioctl_dout = 8'h77;
    step();
    ioctl_wr = 1'b0;
    n_total++; if (ioctl_wait !== 1'b1) $display("FAIL rml_wait got=%b exp=1", ioctl_wait); else n_pass++;
    reset = 1'b1;
    #1;
    n_total++; if (mem_we !== 1'b0) $display("FAIL rml_we_gated got=%b exp=0", mem_we); else n_pass++;
    step();
    n_total++; if (fsm_state !== S_HOLD) $display("FAIL rml_hold got=%0d exp=%0d", fsm_state, S_HOLD); else n_pass++;
    n_total++; if (dl_done !== 1'b0) $display("FAIL rml_done_clr got=%b exp=0", dl_done); else n_pass++;
    reset = 1'b0;
    step();
    n_total++; if (fsm_state !== S_LOAD) $display("FAIL rml_reenter got=%0d exp=%0d", fsm_state, S_LOAD); else n_pass++;
    n_total++; if (wr_log.size() !== 0) $display("FAIL rml_discard got=%0d exp=0", wr_log.size()); else n_pass++;
    finish_load();
    n_total++; if (dl_done !== 1'b1) $display("FAIL rml_done got=%b exp=1", dl_done); else n_pass++;
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = 8'h00;
    reset = 1'b1;
    ioctl_download = 1'b0;
    ioctl_index = 8'd0;
    ioctl_wr = 1'b0;
    ioctl_addr = '0;
    ioctl_dout = '0;
    cpu_req = 1'b0;
    cpu_addr = '0;
    test_reset();
    test_load();
    test_cpu_read();
    test_oob();
    test_back_to_back();
    test_other_index();
    test_reset_mid_load();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/rom_dl_ctrl.md
ROM_DL_CTRL -- requirements
Module: rom_dl_ctrl

Parameters
REQ-001 SHALL provide ROM_SIZE, default 16384, number of writable program-memory bytes (power of two, at most 16384).
REQ-002 SHALL provide HOLD_CYCLES, default 256, number of core-reset hold cycles after load or reset (at least 1).
REQ-003 SHALL provide DL_INDEX, default 8'd0, ioctl_index value that selects this loader.

Interface
REQ-004 clk_sys  in  1  sole clock; all logic on rising edge.
REQ-005 reset  in  1  synchronous, active-high.
REQ-006 ioctl_download  in  1  HPS download in progress.
REQ-007 ioctl_index  in  8  download target index.
REQ-008 ioctl_wr  in  1  byte-valid strobe, one cycle per byte.
REQ-009 ioctl_addr  in  25  byte address.
REQ-010 ioctl_dout  in  8  byte data.
REQ-011 ioctl_wait  out  1  back-pressure to HPS.
REQ-012 cpu_req  in  1  CPU read request.
REQ-013 cpu_addr  in  14  CPU read address.
REQ-014 cpu_ack  out  1  one-cycle read-data-valid pulse.
REQ-015 cpu_rdata  out  8  read data, valid when cpu_ack is 1.
REQ-016 mem_addr  out  14  single-port RAM address.
REQ-017 mem_din  out  8  RAM write data.
REQ-018 mem_we  out  1  RAM write enable.
REQ-019 mem_dout  in  8  RAM read data; 1-cycle registered read latency.
REQ-020 core_reset  out  1  reset to the game core, active-high.
REQ-021 dl_done  out  1  sticky flag: at least one complete load has finished.
REQ-022 dl_err  out  1  sticky flag: overflow or dropped byte; cleared at next load start.

Function
REQ-023 States SHALL be HOLD, RUN, LOAD and DRAIN.
REQ-024 Load start: cycle with ioctl_download=1 & ioctl_index==DL_INDEX SHALL enter LOAD from any state, set core_reset=1, clear dl_err, drop any CPU request in flight.
REQ-025 Other indices: downloads with ioctl_index!=DL_INDEX SHALL be ignored entirely (no state change, no writes, no wait).
REQ-026 LOAD, byte capture: ioctl_wr=1 with buffer empty SHALL capture {ioctl_addr[13:0], ioctl_dout} into a 1-entry buffer.
REQ-027 LOAD, write-out: the buffer SHALL write to RAM on the next cycle (mem_we=1, mem_addr=buffered addr, mem_din=buffered data), then go empty.
REQ-028 ioctl_wait SHALL equal buffer-full, registered.
REQ-029 ioctl_wr while buffer full SHALL drop the byte and set dl_err.
REQ-030 ioctl_addr >= ROM_SIZE SHALL not be captured, SHALL produce no RAM write, and SHALL set dl_err.
REQ-031 Falling ioctl_download in LOAD SHALL go to DRAIN; DRAIN SHALL exit to HOLD once the buffer is empty (pending byte still written).
REQ-032 HOLD: core_reset=1; a counter SHALL run from 0 to HOLD_CYCLES-1, then the state SHALL go to RUN; dl_done SHALL be set on HOLD exit if HOLD was entered from DRAIN.
REQ-033 RUN: core_reset=0; cpu_req=1 SHALL drive mem_addr=cpu_addr, mem_we=0.
REQ-034 RUN: cpu_ack SHALL pulse exactly one cycle after the request cycle, with cpu_rdata=mem_dout.
REQ-035 RUN: back-to-back requests SHALL be accepted every cycle (throughput 1/clk).
REQ-036 Outside RUN, cpu_req SHALL be ignored and cpu_ack SHALL stay 0; in RUN, mem_we SHALL be 0.
REQ-037 Download writes SHALL always have priority; CPU never stalls the HPS.

Reset
REQ-038 reset=1 SHALL force HOLD with counter=0, buffer empty, core_reset=1, ioctl_wait=0, mem_we=0, cpu_ack=0, cpu_rdata=0, dl_done=0, dl_err=0.
REQ-039 reset asserted mid-LOAD SHALL abort the load: the pending byte is discarded and not written.
REQ-040 If ioctl_download is still 1 after reset releases, the block SHALL re-enter LOAD on the following cycle.

Verification
REQ-041 Reset release, no download -> core_reset=1 for exactly 256 cycles, then RUN; dl_done=0.
REQ-042 Index 0 load of 4 bytes at 0x0000-0x0003 (AA,BB,CC,DD), one ioctl_wr every 4 cycles -> 4 mem_we pulses with matching addr/data, ioctl_wait 1 cycle per byte; dl_done=1 after 256 HOLD cycles.
REQ-043 Byte at addr 0x4000 with ROM_SIZE=16384 -> no mem_we, dl_err=1, load still completes.
REQ-044 ioctl_wr on two consecutive cycles -> second byte dropped, dl_err=1.
REQ-045 In RUN, cpu_req at 0x0002 then 0x0003 on consecutive cycles -> cpu_ack on the next two cycles with rdata CC then DD.
REQ-046 ioctl_index=1 download -> no state change, no mem_we, core_reset unchanged.
